// File: rtl/spi_controller_mcs.sv
`default_nettype none
// ============================================================================
// Module      : spi_controller_mcs
// Description : Parametrised full-duplex SPI controller with a small host
//               register file. Per-transfer word length, N_CS active-low chip
//               selects, CPOL/CPHA and LSB/MSB-first order are configurable.
// Optional    : SPI_LOOPBACK_EN - makes MODE[3] writable. When MODE[3]=1 the
//               RX path samples o_copi, and the chip selects stay high.
// Ports       : i_clk/i_rst_n     clock, synchronous active-low reset
//               i_ws_n/i_rs_n     register write/read strobes (active-low)
//               i_addr/i_data     register address, write data / TX word
//               i_request_tx      start a transfer of i_data when o_ready
//               o_data/o_rx_valid last received word, 1-cycle update pulse
//               o_reg_data        register read data (one cycle after i_rs_n)
//               o_ready           idle, accepting requests and config writes
//               o_sclk/o_copi/i_cipo/o_cs_n  SPI pins
// Revision    : 1.0 - initial release
// ============================================================================
module spi_controller_mcs #(
  parameter int DATA_W = 8,
  parameter int N_CS   = 4,
  parameter int DIV_W  = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_ws_n,
  input  logic              i_rs_n,
  input  logic [2:0]        i_addr,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_request_tx,
  output logic [DATA_W-1:0] o_data,
  output logic [DATA_W-1:0] o_reg_data,
  output logic              o_ready,
  output logic              o_rx_valid,
  output logic              o_sclk,
  output logic              o_copi,
  input  logic              i_cipo,
  output logic [N_CS-1:0]   o_cs_n
);

  // CW holds 2*DATA_W (sclk edge count); IW indexes a bit of a word.
  localparam int CW = $clog2(2 * DATA_W + 1);
  localparam int IW = $clog2(DATA_W);
  localparam logic [DATA_W-1:0] LEN_MAX = DATA_W'(DATA_W);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LEAD  = 3'd1,
    S_SHIFT = 3'd2,
    S_TRAIL = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  state_e state_q, state_d;

  logic [3:0]        mode_q;
  logic [DATA_W-1:0] cs_sel_q, word_len_q, tx_q, rx_q, data_q, reg_data_q;
  logic [DIV_W-1:0]  clk_div_q, hcnt_q;
  logic [CW-1:0]     edge_q;
  logic              sclk_q, copi_q, sticky_q;

  logic              cpol_w, cpha_w, lsb_w, loop_w, busy_w, start_w, wr_en_w;
  logic              half_done_w, last_edge_w, sample_w, rx_in_w, cs_act_w;
  logic [DIV_W-1:0]  div_eff_w, half_m1_w;
  logic [CW-1:0]     len_w, bit_idx_w, next_idx_w;
  logic [N_CS-1:0]   cs_n_w;
  logic [DATA_W-1:0] rd_w;

  assign cpha_w = mode_q[0];
  assign cpol_w = mode_q[1];
  assign lsb_w  = mode_q[2];
`ifdef SPI_LOOPBACK_EN
  assign loop_w = mode_q[3];
`else
  assign loop_w = 1'b0;
`endif

  // Effective divider: 0/1 behave as 2, odd values round down via the >>1.
  assign div_eff_w   = (clk_div_q < DIV_W'(2)) ? DIV_W'(2) : clk_div_q;
  assign half_m1_w   = (div_eff_w >> 1) - DIV_W'(1);
  assign half_done_w = (hcnt_q == half_m1_w);

  assign len_w = (word_len_q == '0 || word_len_q > LEN_MAX) ? CW'(DATA_W) : CW'(word_len_q);

  // edge_q counts sclk toggles inside SHIFT; even = leading, odd = trailing.
  assign last_edge_w = (edge_q == ((len_w << 1) - CW'(1)));
  assign bit_idx_w   = edge_q >> 1;
  assign next_idx_w  = bit_idx_w + CW'(1);
  assign sample_w    = (edge_q[0] == cpha_w);
  assign rx_in_w     = loop_w ? copi_q : i_cipo;

  assign busy_w  = (state_q != S_IDLE);
  assign start_w = !busy_w && i_request_tx;
  assign wr_en_w = !busy_w && !i_ws_n;

  // Bit k of the serial stream in transmit order.
  function automatic logic pick_bit(input logic [DATA_W-1:0] w, input logic [CW-1:0] k,
                                    input logic [CW-1:0] len, input logic lsb);
    logic [CW-1:0] idx;
    idx = lsb ? k : (len - k - CW'(1));
    return w[IW'(idx)];
  endfunction

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (i_request_tx) state_d = S_LEAD;
      S_LEAD:  if (half_done_w) state_d = S_SHIFT;
      S_SHIFT: if (half_done_w && last_edge_w) state_d = S_TRAIL;
      S_TRAIL: if (half_done_w) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------- config
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      cs_sel_q   <= '0;
      mode_q     <= '0;
      clk_div_q  <= DIV_W'(4);
      word_len_q <= LEN_MAX;
    end else if (wr_en_w) begin
      case (i_addr)
        3'd2: cs_sel_q <= i_data;
`ifdef SPI_LOOPBACK_EN
        3'd3: mode_q <= i_data[3:0];
`else
        3'd3: mode_q <= {1'b0, i_data[2:0]};
`endif
        3'd4: clk_div_q  <= DIV_W'(i_data);
        3'd5: word_len_q <= i_data;
        default: ;
      endcase
    end
  end

  always_comb begin
    rd_w = '0;
    case (i_addr)
      3'd1: rd_w = DATA_W'({busy_w, sticky_q, !busy_w});
      3'd2: rd_w = cs_sel_q;
      3'd3: rd_w = DATA_W'(mode_q);
      3'd4: rd_w = DATA_W'(clk_div_q);
      3'd5: rd_w = word_len_q;
      default: rd_w = '0;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n)    reg_data_q <= '0;
    else if (!i_rs_n) reg_data_q <= rd_w;
  end

  // ---------------------------------------------------------------- datapath
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      hcnt_q   <= '0;
      edge_q   <= '0;
      tx_q     <= '0;
      rx_q     <= '0;
      data_q   <= '0;
      sclk_q   <= 1'b0;
      copi_q   <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      if (!busy_w || half_done_w) hcnt_q <= '0;
      else                        hcnt_q <= hcnt_q + DIV_W'(1);

      if (start_w) begin
        tx_q   <= i_data;
        rx_q   <= '0;
        edge_q <= '0;
        // CPHA=0 needs the first bit on the line before the first leading edge.
        if (!cpha_w) copi_q <= pick_bit(i_data, '0, len_w, lsb_w);
      end

      if (state_q == S_SHIFT && half_done_w) begin
        sclk_q <= ~sclk_q;
        edge_q <= edge_q + CW'(1);
        if (sample_w) begin
          if (lsb_w) rx_q[IW'(bit_idx_w)] <= rx_in_w;
          else       rx_q <= {rx_q[DATA_W-2:0], rx_in_w};
        end else if (!cpha_w) begin
          if (next_idx_w < len_w) copi_q <= pick_bit(tx_q, next_idx_w, len_w, lsb_w);
        end else begin
          copi_q <= pick_bit(tx_q, bit_idx_w, len_w, lsb_w);
        end
      end else if (state_q != S_SHIFT) begin
        sclk_q <= cpol_w;
      end

      if (state_q == S_TRAIL && half_done_w) begin
        data_q   <= rx_q;
        sticky_q <= 1'b1;
      end else if (!i_rs_n && i_addr == 3'd1) begin
        sticky_q <= 1'b0;
      end
    end
  end

  // Out-of-range CS_SEL matches no index, so no select asserts.
  assign cs_act_w = !loop_w && (state_q == S_LEAD || state_q == S_SHIFT || state_q == S_TRAIL);
  always_comb begin
    cs_n_w = '1;
    for (int i = 0; i < N_CS; i++) begin
      cs_n_w[i] = !(cs_act_w && (cs_sel_q == DATA_W'(i)));
    end
  end

  assign o_data     = data_q;
  assign o_reg_data = reg_data_q;
  assign o_ready    = !busy_w;
  assign o_rx_valid = (state_q == S_DONE);
  assign o_sclk     = sclk_q;
  assign o_copi     = copi_q;
  assign o_cs_n     = cs_n_w;

endmodule
`default_nettype wire

// File: tb/tb_spi_controller_mcs.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_controller_mcs
// Description : Self-checking bench for spi_controller_mcs (DATA_W=8, N_CS=4).
//               An SPI peripheral model answers each transfer; expected words,
//               bit order, pulse count and latency come from the transfer rules.
// Optional    : SPI_LOOPBACK_EN enables the loopback checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_controller_mcs;

  logic       i_clk = 1'b0;
  logic       i_rst_n = 1'b0;
  logic       i_ws_n = 1'b1;
  logic       i_rs_n = 1'b1;
  logic [2:0] i_addr = '0;
  logic [7:0] i_data = '0;
  logic       i_request_tx = 1'b0;
  logic       i_cipo = 1'b0;
  logic [7:0] o_data, o_reg_data;
  logic       o_ready, o_rx_valid, o_sclk, o_copi;
  logic [3:0] o_cs_n;

  int n_vec = 0;
  int n_err = 0;

  spi_controller_mcs #(.DATA_W(8), .N_CS(4), .DIV_W(8)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_ws_n(i_ws_n), .i_rs_n(i_rs_n),
    .i_addr(i_addr), .i_data(i_data), .i_request_tx(i_request_tx),
    .o_data(o_data), .o_reg_data(o_reg_data), .o_ready(o_ready),
    .o_rx_valid(o_rx_valid), .o_sclk(o_sclk), .o_copi(o_copi),
    .i_cipo(i_cipo), .o_cs_n(o_cs_n)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    i_ws_n = 1'b0; i_addr = a; i_data = d;
    @(negedge i_clk);
    i_ws_n = 1'b1;
  endtask

  task automatic rd(input logic [2:0] a, output logic [7:0] v);
    i_rs_n = 1'b0; i_addr = a;
    @(negedge i_clk);
    i_rs_n = 1'b1;
    v = o_reg_data;
  endtask

  // One full transfer with the given (already written) configuration.
  task automatic xfer(input logic [7:0] tx, input logic [7:0] rx, input int len_cfg,
                      input int div_cfg, input logic [3:0] mode, input int cs_cfg,
                      input string tag);
    int len, h, t, cyc, nb, idx;
    logic cpha, cpol, lsb, lp, prev, cs_bad;
    logic [7:0] exp_seq, exp_rx, got_seq;
    logic [3:0] exp_cs;
    len = (len_cfg == 0 || len_cfg > 8) ? 8 : len_cfg;
    h = (div_cfg < 2) ? 1 : div_cfg / 2;
    cpha = mode[0]; cpol = mode[1]; lsb = mode[2];
`ifdef SPI_LOOPBACK_EN
    lp = mode[3];
`else
    lp = 1'b0;
`endif
    exp_cs = 4'hF;
    if (!lp && cs_cfg < 4) exp_cs[cs_cfg] = 1'b0;
    exp_seq = '0; exp_rx = '0; got_seq = '0;
    for (int k = 0; k < len; k++) begin
      exp_seq[k] = tx[lsb ? k : len - 1 - k];
      exp_rx[k]  = lp ? tx[k] : rx[k];
    end
    i_data = tx; i_request_tx = 1'b1;
    i_cipo = lp ? 1'b1 : rx[lsb ? 0 : len - 1];
    @(negedge i_clk);
    i_request_tx = 1'b0;
    t = 0; cyc = 0; nb = 0; cs_bad = 1'b0; prev = o_sclk;
    while (!o_rx_valid && cyc < 4000) begin
      if (o_cs_n !== exp_cs) cs_bad = 1'b1;
      if (o_sclk !== prev) begin
        if ((t % 2) == int'(cpha)) begin
          if (nb < 8) got_seq[nb] = o_copi;
          nb++;
        end
        t++;
        prev = o_sclk;
      end
      // Peripheral: next bit goes out after the edge on which the controller shifts.
      idx = (t + (cpha ? 0 : 1)) / 2;
      if (!lp && idx < len) i_cipo = rx[lsb ? idx : len - 1 - idx];
      @(negedge i_clk);
      cyc++;
    end
    chk({tag, ".rx_valid"}, 32'(o_rx_valid), 32'd1);
    chk({tag, ".data"},     32'(o_data), 32'(exp_rx));
    chk({tag, ".copi"},     32'(got_seq), 32'(exp_seq));
    chk({tag, ".edges"},    32'(t), 32'(2 * len));
    chk({tag, ".latency"},  32'(cyc), 32'(h * (2 + 2 * len)));
    chk({tag, ".cs"},       32'(cs_bad), 32'd0);
    chk({tag, ".cs_done"},  32'(o_cs_n), 32'hF);
    @(negedge i_clk);
    chk({tag, ".pulse1"},   32'(o_rx_valid), 32'd0);
    chk({tag, ".ready"},    32'(o_ready), 32'd1);
    chk({tag, ".idle_sclk"}, 32'(o_sclk), 32'(cpol));
  endtask

  initial begin
    logic [7:0] v;
    logic [3:0] m;
    int dv, ln, cs, cyc;
    logic bad;
    int divs[4] = '{4, 8, 12, 16};

    // ---- reset
    repeat (10) @(negedge i_clk);
    i_rst_n = 1'b1;
    @(negedge i_clk);
    chk("rst.ready", 32'(o_ready), 32'd1);
    chk("rst.rx_valid", 32'(o_rx_valid), 32'd0);
    chk("rst.data", 32'(o_data), 32'd0);
    chk("rst.reg_data", 32'(o_reg_data), 32'd0);
    chk("rst.sclk", 32'(o_sclk), 32'd0);
    chk("rst.copi", 32'(o_copi), 32'd0);
    chk("rst.cs_n", 32'(o_cs_n), 32'hF);
    rd(3'd1, v); chk("rst.status", 32'(v), 32'h1);
    rd(3'd3, v); chk("rst.mode", 32'(v), 32'h0);
    rd(3'd4, v); chk("rst.clk_div", 32'(v), 32'h4);
    rd(3'd5, v); chk("rst.word_len", 32'(v), 32'h8);
    rd(3'd2, v); chk("rst.cs_sel", 32'(v), 32'h0);
    wr(3'd6, 8'hFF);
    rd(3'd6, v); chk("rd.addr6", 32'(v), 32'h0);
    rd(3'd0, v); chk("rd.addr0", 32'(v), 32'h0);

    // ---- directed A5 / 3C on CS 2
    wr(3'd2, 8'd2);
    xfer(8'hA5, 8'h3C, 8, 4, 4'd0, 2, "basic");
    rd(3'd1, v); chk("status.sticky", 32'(v), 32'h3);
    rd(3'd1, v); chk("status.cleared", 32'(v), 32'h1);

    // ---- all modes x dividers, random words
    for (int mi = 0; mi < 4; mi++) begin
      for (int di = 0; di < 4; di++) begin
        wr(3'd3, 8'(mi)); wr(3'd4, 8'(divs[di])); wr(3'd5, 8'd8);
        cs = $urandom_range(0, 3); wr(3'd2, 8'(cs));
        for (int n = 0; n < 16; n++)
          xfer(8'($urandom), 8'($urandom), 8, divs[di], 4'(mi), cs, "rand");
      end
    end

    // ---- LSB-first, 5-bit word
    wr(3'd3, 8'd4); wr(3'd4, 8'd4); wr(3'd5, 8'd5); wr(3'd2, 8'd1);
    xfer(8'h13, 8'h16, 5, 4, 4'd4, 1, "len5");

    // ---- boundary configs: odd/small dividers, bad lengths, CS out of range
    for (int n = 0; n < 40; n++) begin
      m = 4'($urandom_range(0, 7)); ln = $urandom_range(0, 12);
      dv = $urandom_range(0, 9); cs = $urandom_range(0, 5);
      wr(3'd3, 8'(m)); wr(3'd5, 8'(ln)); wr(3'd4, 8'(dv)); wr(3'd2, 8'(cs));
      rd(3'd5, v); chk("bnd.word_len_rd", 32'(v), 32'(ln));
      xfer(8'($urandom), 8'($urandom), ln, dv, m, cs, "bnd");
    end

    // ---- request and MODE write while busy are ignored
    wr(3'd3, 8'd0); wr(3'd4, 8'd4); wr(3'd5, 8'd8); wr(3'd2, 8'd0);
    i_data = 8'hC3; i_request_tx = 1'b1;
    @(negedge i_clk);
    i_request_tx = 1'b0;
    repeat (6) @(negedge i_clk);
    i_request_tx = 1'b1; i_ws_n = 1'b0; i_addr = 3'd3; i_data = 8'h03;
    @(negedge i_clk);
    i_request_tx = 1'b0; i_ws_n = 1'b1;
    cyc = 0;
    while (!o_rx_valid && cyc < 200) begin @(negedge i_clk); cyc++; end
    chk("busy.first_done", 32'(o_rx_valid), 32'd1);
    bad = 1'b0;
    repeat (60) begin
      @(negedge i_clk);
      if (o_rx_valid || !o_ready) bad = 1'b1;
    end
    chk("busy.no_second", 32'(bad), 32'd0);
    rd(3'd3, v); chk("busy.mode_kept", 32'(v), 32'h0);

    // ---- reset in the middle of SHIFT (CPOL=1 so sclk must drop)
    wr(3'd3, 8'd3); wr(3'd2, 8'd3);
    i_data = 8'h81; i_request_tx = 1'b1;
    @(negedge i_clk);
    i_request_tx = 1'b0;
    repeat (8) @(negedge i_clk);
    chk("abort.cs_active", 32'(o_cs_n), 32'h7);
    i_rst_n = 1'b0;
    @(negedge i_clk);
    chk("abort.cs_n", 32'(o_cs_n), 32'hF);
    chk("abort.sclk", 32'(o_sclk), 32'd0);
    chk("abort.ready", 32'(o_ready), 32'd1);
    chk("abort.data", 32'(o_data), 32'd0);
    i_rst_n = 1'b1;
    bad = 1'b0;
    repeat (60) begin
      @(negedge i_clk);
      if (o_rx_valid) bad = 1'b1;
    end
    chk("abort.no_valid", 32'(bad), 32'd0);
    rd(3'd1, v); chk("abort.status", 32'(v), 32'h1);
    rd(3'd3, v); chk("abort.mode", 32'(v), 32'h0);

    // ---- loopback
`ifdef SPI_LOOPBACK_EN
    wr(3'd3, 8'h08); wr(3'd2, 8'd0);
    xfer(8'h5A, 8'h00, 8, 4, 4'b1000, 0, "loop");
`else
    wr(3'd3, 8'h0F);
    rd(3'd3, v); chk("mode.bit3_ro", 32'(v), 32'h7);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
